// File: rtl/pc_seq_pkg.sv
// Shared encodings for the PC sequencer: JumpOP values, sequencer states, PC width
// and a saturating counter helper.
package pc_seq_pkg;

    localparam int unsigned PC_W = 32;

    localparam logic [1:0] JUMP_TO_PCOUT_PLUS4 = 2'd0;
    localparam logic [1:0] JUMP_TO_BRANCH      = 2'd1;
    localparam logic [1:0] JUMP_TO_JR          = 2'd2;
    localparam logic [1:0] JUMP_TO_JUMP        = 2'd3;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        WAIT_MEM = 2'd1,
        FLUSH    = 2'd2
    } pc_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pc_target_mux.sv
// Selects the redirect target by JumpOP and forces word alignment on the result.
module pc_target_mux
    import pc_seq_pkg::*;
(
    input  logic [1:0]      jump_op,
    input  logic [PC_W-1:0] pc_plus4,
    input  logic [PC_W-1:0] branch_target,
    input  logic [PC_W-1:0] jr_target,
    input  logic [PC_W-1:0] jump_target,
    output logic [PC_W-1:0] target
);

    logic [PC_W-1:0] raw_s;

    // target selection with word-alignment mask
    always_comb begin
        raw_s = pc_plus4;
        case (jump_op)
            JUMP_TO_BRANCH: raw_s = branch_target;
            JUMP_TO_JR:     raw_s = jr_target;
            JUMP_TO_JUMP:   raw_s = jump_target;
            default:        raw_s = pc_plus4;
        endcase
        target = {raw_s[PC_W-1:2], 2'b00};
    end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// PC sequencer: owns the PC, runs the imem handshake, buffers redirects during
// memory waits and flushes IF/ID + ID/EX. Optional counters: PC_REDIRECT_STATS_EN.
module pc_redirect_ctrl
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  jump_op,
    input  logic        redirect_valid,
    input  logic [31:0] branch_target,
    input  logic [31:0] jr_target,
    input  logic [31:0] jump_target,
    input  logic        stall_in,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc_plus4,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_flush
`ifdef PC_REDIRECT_STATS_EN
    ,
    output logic [15:0] br_cnt,
    output logic [15:0] jr_cnt,
    output logic [15:0] j_cnt
`endif
);

    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYCLES - 1);

    pc_state_e       state_r;
    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] pc_plus4_s;
    logic [PC_W-1:0] sel_target_s;
    logic            pend_valid_r;
    logic [PC_W-1:0] pend_target_r;
    logic [1:0]      pend_op_r;
    logic [1:0]      flush_cnt_r;
    logic            redirect_taken_s;
    logic            accepted_s;
    logic            eff_valid_s;
    logic [PC_W-1:0] eff_target_s;
    logic [1:0]      eff_op_s;
    logic            load_s;

    assign pc_plus4_s = pc_r + 32'd4;
    assign imem_addr  = pc_r;
    assign pc_plus4   = pc_plus4_s;

    pc_target_mux u_mux (
        .jump_op       (jump_op),
        .pc_plus4      (pc_plus4_s),
        .branch_target (branch_target),
        .jr_target     (jr_target),
        .jump_target   (jump_target),
        .target        (sel_target_s)
    );

    // a fresh redirect overrides the buffered one (last wins)
    always_comb begin
        redirect_taken_s = redirect_valid && (jump_op != JUMP_TO_PCOUT_PLUS4);
        accepted_s       = imem_req && imem_ready;
        eff_valid_s      = redirect_taken_s || pend_valid_r;
        eff_target_s     = redirect_taken_s ? sel_target_s : pend_target_r;
        eff_op_s         = redirect_taken_s ? jump_op : pend_op_r;
        if ((state_r == FETCH) || (state_r == WAIT_MEM)) begin
            load_s = accepted_s && eff_valid_s && ((state_r == WAIT_MEM) || redirect_taken_s);
        end else begin
            load_s = 1'b0;
        end
    end

    // sequencer state, PC, pending buffer and registered pipeline controls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= FETCH;
            pc_r          <= RESET_PC;
            imem_req      <= 1'b0;
            if_id_write   <= 1'b0;
            if_id_flush   <= 1'b0;
            id_ex_flush   <= 1'b0;
            pend_valid_r  <= 1'b0;
            pend_target_r <= 32'h0000_0000;
            pend_op_r     <= 2'd0;
            flush_cnt_r   <= 2'd0;
        end else begin
            imem_req    <= 1'b1;
            if_id_write <= 1'b0;
            if (load_s) begin
                pc_r         <= eff_target_s;
                pend_valid_r <= 1'b0;
                state_r      <= FLUSH;
                flush_cnt_r  <= FLUSH_INIT;
                if_id_flush  <= 1'b1;
                id_ex_flush  <= 1'b1;
            end else begin
                case (state_r)
                    FETCH: begin
                        if (redirect_taken_s) begin
                            pend_valid_r  <= 1'b1;
                            pend_target_r <= sel_target_s;
                            pend_op_r     <= eff_op_s;
                            state_r       <= WAIT_MEM;
                        end else if (stall_in) begin
                            state_r <= FETCH;
                        end else if (accepted_s) begin
                            pc_r        <= pc_plus4_s;
                            if_id_write <= 1'b1;
                        end else if (imem_req) begin
                            state_r <= WAIT_MEM;
                        end else begin
                            state_r <= FETCH;
                        end
                    end
                    WAIT_MEM: begin
                        if (imem_ready) begin
                            pc_r        <= pc_plus4_s;
                            if_id_write <= 1'b1;
                            state_r     <= FETCH;
                        end else if (redirect_taken_s) begin
                            pend_valid_r  <= 1'b1;
                            pend_target_r <= sel_target_s;
                            pend_op_r     <= eff_op_s;
                        end else begin
                            state_r <= WAIT_MEM;
                        end
                    end
                    FLUSH: begin
                        if (accepted_s) begin
                            pc_r <= pc_plus4_s;
                        end else begin
                            pc_r <= pc_r;
                        end
                        if (flush_cnt_r == 2'd0) begin
                            state_r     <= FETCH;
                            if_id_flush <= 1'b0;
                            id_ex_flush <= 1'b0;
                        end else begin
                            flush_cnt_r <= flush_cnt_r - 2'd1;
                        end
                    end
                    default: begin
                        state_r     <= FETCH;
                        if_id_flush <= 1'b0;
                        id_ex_flush <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef PC_REDIRECT_STATS_EN
    // per-type redirect counters, bumped only when the PC takes the target
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt <= 16'd0;
            jr_cnt <= 16'd0;
            j_cnt  <= 16'd0;
        end else if (load_s) begin
            case (eff_op_s)
                JUMP_TO_BRANCH: br_cnt <= sat_inc16(br_cnt);
                JUMP_TO_JR:     jr_cnt <= sat_inc16(jr_cnt);
                JUMP_TO_JUMP:   j_cnt  <= sat_inc16(j_cnt);
                default:        br_cnt <= br_cnt;
            endcase
        end else begin
            br_cnt <= br_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Self-checking bench for pc_redirect_ctrl against a transaction-level PC model.
module tb_pc_redirect_ctrl;

    localparam logic [31:0] RPC = 32'h0000_0000;
    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  jump_op = 2'd0;
    logic        redirect_valid = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic [31:0] jr_target = 32'h0;
    logic [31:0] jump_target = 32'h0;
    logic        stall_in = 1'b0;
    logic        imem_ready = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc_plus4;
    logic        if_id_write;
    logic        if_id_flush;
    logic        id_ex_flush;
`ifdef PC_REDIRECT_STATS_EN
    logic [15:0] br_cnt, jr_cnt, j_cnt;
`endif

    pc_redirect_ctrl #(.RESET_PC(RPC), .FLUSH_CYCLES(FC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .jump_op        (jump_op),
        .redirect_valid (redirect_valid),
        .branch_target  (branch_target),
        .jr_target      (jr_target),
        .jump_target    (jump_target),
        .stall_in       (stall_in),
        .imem_ready     (imem_ready),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .pc_plus4       (pc_plus4),
        .if_id_write    (if_id_write),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush)
`ifdef PC_REDIRECT_STATS_EN
        ,
        .br_cnt         (br_cnt),
        .jr_cnt         (jr_cnt),
        .j_cnt          (j_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // reference model: PC value, whether a request is out, flush cycles left,
    // whether a fetch is waiting on memory, and a last-wins redirect queue
    typedef struct {
        logic [1:0]  op;
        logic [31:0] tgt;
    } redir_t;
    logic [31:0] m_pc;
    bit          m_req;
    bit          m_wr;
    int          m_flush_left;
    bit          m_wait;
    redir_t      m_pend[$];
    int          m_cnt[3];

    function automatic logic [31:0] pick(input logic [1:0] op);
        logic [31:0] t;
        if (op == 2'd1) t = branch_target;
        else if (op == 2'd2) t = jr_target;
        else t = jump_target;
        return t & 32'hFFFF_FFFC;
    endfunction

    task automatic model_reset();
        m_pc = RPC; m_req = 1'b0; m_wr = 1'b0; m_flush_left = 0; m_wait = 1'b0;
        m_pend.delete();
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    endtask

    task automatic model_load(input logic [1:0] op, input logic [31:0] tgt);
        m_pc = tgt;
        m_flush_left = FC;
        if (m_cnt[op - 2'd1] < 65535) m_cnt[op - 2'd1]++;
    endtask

    task automatic model_step();
        bit take, acc;
        take = redirect_valid && (jump_op != 2'd0);
        acc  = m_req && imem_ready;
        m_wr = 1'b0;
        if (m_flush_left > 0) begin
            if (acc) m_pc = m_pc + 32'd4;
            m_flush_left--;
        end else if (m_wait) begin
            if (take) begin
                m_pend.delete();
                m_pend.push_back('{jump_op, pick(jump_op)});
            end
            if (imem_ready) begin
                m_wait = 1'b0;
                if (m_pend.size() > 0) begin
                    model_load(m_pend[0].op, m_pend[0].tgt);
                    m_pend.delete();
                end else begin
                    m_pc = m_pc + 32'd4;
                    m_wr = 1'b1;
                end
            end
        end else begin
            if (take) begin
                if (acc) model_load(jump_op, pick(jump_op));
                else begin
                    m_pend.push_back('{jump_op, pick(jump_op)});
                    m_wait = 1'b1;
                end
            end else if (stall_in) begin
                m_wr = 1'b0;
            end else if (acc) begin
                m_pc = m_pc + 32'd4;
                m_wr = 1'b1;
            end else if (m_req) begin
                m_wait = 1'b1;
            end
        end
        m_req = 1'b1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".imem_req"}, {31'd0, imem_req}, {31'd0, m_req});
        check({tag, ".imem_addr"}, imem_addr, m_pc);
        check({tag, ".pc_plus4"}, pc_plus4, m_pc + 32'd4);
        check({tag, ".if_id_write"}, {31'd0, if_id_write}, {31'd0, m_wr});
        check({tag, ".if_id_flush"}, {31'd0, if_id_flush}, {31'd0, m_flush_left > 0});
        check({tag, ".id_ex_flush"}, {31'd0, id_ex_flush}, {31'd0, m_flush_left > 0});
`ifdef PC_REDIRECT_STATS_EN
        check({tag, ".br_cnt"}, {16'd0, br_cnt}, 32'(m_cnt[0]));
        check({tag, ".jr_cnt"}, {16'd0, jr_cnt}, 32'(m_cnt[1]));
        check({tag, ".j_cnt"}, {16'd0, j_cnt}, 32'(m_cnt[2]));
`endif
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic drive(input bit rv, input logic [1:0] op, input logic [31:0] tgt,
                         input bit st, input bit rdy);
        redirect_valid = rv; jump_op = op; stall_in = st; imem_ready = rdy;
        if (op == 2'd1) branch_target = tgt;
        else if (op == 2'd2) jr_target = tgt;
        else if (op == 2'd3) jump_target = tgt;
    endtask

    task automatic pulse_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // boot with memory always ready
        drive(1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
        cyc("boot0");
        check("boot0.addr_const", imem_addr, 32'h0);
        cyc("boot1");
        check("boot1.addr_const", imem_addr, 32'h4);
        cyc("boot2");
        check("boot2.addr_const", imem_addr, 32'h8);
        for (int i = 0; i < 20 && m_pc != 32'h10; i++) cyc("to10");

        // jump with unaligned target
        drive(1'b1, 2'd3, 32'h0000_0103, 1'b0, 1'b1);
        cyc("jump");
        check("jump.addr_const", imem_addr, 32'h100);
        check("jump.flush_const", {31'd0, if_id_flush}, 32'd1);
        drive(1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc("post_jump");

        // branch landing so the flush exits at 0x20, then stall there
        drive(1'b1, 2'd1, 32'h0000_0018, 1'b0, 1'b1);
        cyc("br18");
        drive(1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
        cyc("br18_f");
        cyc("br18_x");
        drive(1'b0, 2'd0, 32'h0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cyc("stall");
        check("stall.addr_const", imem_addr, 32'h20);
        check("stall.wr_const", {31'd0, if_id_write}, 32'd0);

        // memory not ready for four cycles
        drive(1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc("memwait");
        check("memwait.req_const", {31'd0, imem_req}, 32'd1);
        check("memwait.addr_const", imem_addr, 32'h20);
        drive(1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
        cyc("memwait_done");

        // buffered redirects, last one wins
        pulse_reset("rst_buf");
        cyc("buf_boot");
        drive(1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
        cyc("buf_wait");
        drive(1'b1, 2'd1, 32'h0000_0040, 1'b0, 1'b0);
        cyc("buf_br");
        drive(1'b1, 2'd2, 32'h0000_0080, 1'b0, 1'b0);
        cyc("buf_jr");
        drive(1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
        cyc("buf_load");
        check("buf.addr_const", imem_addr, 32'h80);
`ifdef PC_REDIRECT_STATS_EN
        check("buf.jr_const", {16'd0, jr_cnt}, 32'd1);
        check("buf.br_const", {16'd0, br_cnt}, 32'd0);
`endif
        for (int i = 0; i < 2; i++) cyc("buf_after");

        // wrap from the top of the address space, then reset mid-flush
        drive(1'b1, 2'd3, 32'hFFFF_FFFE, 1'b0, 1'b1);
        cyc("wrap_jump");
        check("wrap.top_const", imem_addr, 32'hFFFF_FFFC);
        drive(1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
        cyc("wrap");
        check("wrap.zero_const", imem_addr, 32'h0);
        check("wrap.flush_const", {31'd0, id_ex_flush}, 32'd1);
        pulse_reset("rst_midflush");
        check("rst_midflush.flush_const", {31'd0, if_id_flush}, 32'd0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            redirect_valid = ($urandom_range(0, 3) == 0);
            jump_op        = 2'($urandom_range(0, 3));
            branch_target  = $urandom;
            jr_target      = $urandom;
            jump_target    = $urandom;
            stall_in       = ($urandom_range(0, 4) == 0);
            imem_ready     = ($urandom_range(0, 9) < 7);
            cyc("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Sequencer for the program counter in the pipelined MIPS core.
- Consumes the 2-bit JumpOP encoding and the three candidate targets, and owns the PC register.
- Runs the instruction-memory request/ready handshake.
- Issues IF/ID and ID/EX flushes on redirects.
- Buffers a redirect that arrives while instruction memory is still busy.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FLUSH_CYCLES, 1, flush cycles after a redirect (legal range 1..3).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- jump_op  in  2  0=PC+4, 1=branch, 2=jr, 3=jump.
- redirect_valid  in  1  jump_op is valid this cycle (EX stage resolved).
- branch_target  in  32  branch target address.
- jr_target  in  32  register-indirect target address.
- jump_target  in  32  absolute jump target address.
- stall_in  in  1  load-use stall from the hazard unit.
- imem_ready  in  1  instruction memory has accepted imem_addr.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; equals the PC register.
- pc_plus4  out  32  imem_addr + 4, wraps modulo 2^32.
- if_id_write  out  1  IF/ID pipeline register enable.
- if_id_flush  out  1  zero the IF/ID register.
- id_ex_flush  out  1  zero the ID/EX register.

Behaviour:
- Clock and reset: one clock domain, clk. rst_n is asynchronous and active-low.
- Reset values: PC=RESET_PC, state=FETCH, imem_req=0, if_id_write=0, both flushes=0, pending buffer empty, flush counter=0.
- First request: imem_req rises on the first clk edge after rst_n deasserts. Asserting rst_n mid-operation aborts any wait, flush or pending redirect immediately.
- Target alignment: bits [1:0] of every selected target are forced to 0.
- States:
  - FETCH:
    - imem_req=1.
    - Redirect taken = redirect_valid && jump_op!=0. It has priority over stall_in.
    - Redirect taken and imem_ready=1: next PC = selected target; go to FLUSH with counter=FLUSH_CYCLES-1.
    - Redirect taken and imem_ready=0: latch the target into the pending buffer; go to WAIT_MEM.
    - No redirect, stall_in=1: PC holds and if_id_write=0.
    - No redirect, stall_in=0: if imem_ready=1, PC <= pc_plus4 and if_id_write=1. If imem_ready=0, PC holds and go to WAIT_MEM.
  - WAIT_MEM:
    - imem_req=1, PC holds, if_id_write=0.
    - A redirect arriving here overwrites the pending buffer; last one wins.
    - On imem_ready=1: if the buffer is full, load PC from it, clear it, and go to FLUSH. Otherwise, PC <= pc_plus4 and go to FETCH.
  - FLUSH:
    - if_id_flush=1 and id_ex_flush=1. imem_req=1 at the new PC.
    - PC advances normally on imem_ready.
    - redirect_valid is ignored, because the flushed stages cannot produce one.
    - When the counter reaches 0 and the state exits, go to FETCH.
- Flush timing: flushes are asserted in the cycle after the redirect edge. Exactly FLUSH_CYCLES consecutive cycles are flushed.
- Redirect vs. stall: stall_in=1 together with a redirect is resolved in favour of the redirect, and the stall is dropped.
- jump_op=0 with redirect_valid=1 is treated as no redirect.

Optional Feature:
- Macro: PC_REDIRECT_STATS_EN.
- Defined:
  - Adds outputs br_cnt, jr_cnt and j_cnt, each 16 bits.
  - Each counter increments once per redirect of its type when the PC actually loads the target. Overwritten pending redirects are not counted.
  - Counters saturate at 16'hFFFF and reset to 0.
- Undefined: no counters and no ports; the logic is otherwise identical.

Decomposition:
- Package pc_seq_pkg holds:
  - JumpOP encodings: JUMP_TO_PCOUT_PLUS4=0, JUMP_TO_BRANCH=1, JUMP_TO_JR=2, JUMP_TO_JUMP=3.
  - State enum: FETCH, WAIT_MEM, FLUSH.
  - PC width constant: 32.
- Sub-module pc_target_mux: combinational selection of target by jump_op, plus the alignment mask.

Test Plan:
- Reset release with imem_ready=1 held:
  - imem_addr sequence is 0x0, 0x4, 0x8 on successive edges.
  - if_id_write=1 and no flushes.
- Jump at PC=0x10, jump_op=3, jump_target=0x103, FLUSH_CYCLES=2:
  - Next imem_addr=0x100.
  - Both flushes high for exactly 2 cycles, then imem_addr=0x104, 0x108.
- Stall and imem wait:
  - stall_in=1 for 3 cycles at PC=0x20: PC holds at 0x20 and if_id_write=0.
  - imem_ready=0 for 4 cycles: imem_req stays 1 and PC holds.
- Buffered redirect:
  - Branch (target 0x40) arrives, then jr (target 0x80) arrives, both during WAIT_MEM.
  - On imem_ready, PC=0x80. With PC_REDIRECT_STATS_EN defined, jr_cnt=1 and br_cnt=0.
- Boundary and reset:
  - PC=0xFFFF_FFFC with imem_ready: PC wraps to 0x0.
  - rst_n pulsed low mid-FLUSH: flushes go to 0 immediately and PC=RESET_PC.
